// File: rtl/switch_pkg.sv
// Shared types and constants for the switch input-port receiver.
package switch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SA,
        ST_LEN,
        ST_PAY,
        ST_DROP
    } rx_state_e;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } rx_entry_t;

    localparam int DA_OFS    = 0;
    localparam int SA_OFS    = 1;
    localparam int LEN_OFS   = 2;
    localparam int HDR_BYTES = 3;

endpackage

// File: rtl/switch_rx_fifo.sv
// Packet buffer with speculative write pointer: bytes become readable only
// after commit, and an uncommitted packet can be rolled back in one cycle.
module switch_rx_fifo
    import switch_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  rx_entry_t                wr_entry,
    input  logic                     commit,
    input  logic                     rollback,
    input  logic                     pop,
    output rx_entry_t                rd_entry,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    rx_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     wr_commit;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     used;
    logic              pop_fire;
    logic              wr_fire;

    assign used     = wr_ptr - rd_ptr;
    assign rd_valid = (rd_ptr != wr_commit);
    assign pop_fire = pop && rd_valid;
    // A pop in the same cycle frees the slot the write is about to land in.
    assign full     = (used == PW'(DEPTH)) && !pop_fire;
    assign free     = PW'(DEPTH) - used + PW'(pop_fire);
    assign wr_fire  = wr_en && !full && !rollback;
    assign rd_entry = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
        end else begin
            if (rollback)     wr_ptr <= wr_commit;
            else if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
            if (commit)       wr_commit <= wr_ptr;
            if (pop_fire)     rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/switch_port_rx.sv
// Store-and-forward receiver for one switch input port: parses DA/SA/LEN/payload,
// validates length, commits good packets and rolls back bad ones.
module switch_port_rx
    import switch_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_LEN    = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data,
    input  logic             status,
    output logic             busy,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] pkt_ok_cnt,
    output logic [CNT_W-1:0] pkt_drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = $clog2(MAX_LEN + 1);
    localparam logic [7:0] LEN_LIM = 8'(MAX_LEN);

    rx_state_e     state, nxt;
    logic [RW-1:0] rem, rem_nxt;
    logic          fresh;
    logic          wr_en, commit, drop, full;
    rx_entry_t     wr_entry, rd_entry;
    logic [PW-1:0] free;

    switch_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_entry (wr_entry),
        .commit   (commit),
        .rollback (drop),
        .pop      (out_ready),
        .rd_entry (rd_entry),
        .rd_valid (out_valid),
        .full     (full),
        .free     (free)
    );

    assign out_data = rd_entry.data;
    assign out_sop  = rd_entry.sop;
    assign out_eop  = rd_entry.eop;
    assign busy     = free < PW'(MAX_LEN + HDR_BYTES);

    always_comb begin
        nxt      = state;
        rem_nxt  = rem;
        wr_en    = 1'b0;
        commit   = 1'b0;
        drop     = 1'b0;
        wr_entry = '{sop: 1'b0, eop: 1'b0, data: data};
        case (state)
            ST_IDLE: if (status) begin
                // First byte after reset may be mid-packet; never treat it as DA.
                if (fresh)     nxt = ST_DROP;
                else if (full) drop = 1'b1;
                else begin
                    wr_en        = 1'b1;
                    wr_entry.sop = 1'b1;
                    nxt          = ST_SA;
                end
            end
            ST_SA: begin
                if (!status || full) drop = 1'b1;
                else begin
                    wr_en = 1'b1;
                    nxt   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (!status || data > LEN_LIM || full) drop = 1'b1;
                else begin
                    wr_en        = 1'b1;
                    wr_entry.eop = (data == 8'd0);
                    rem_nxt      = RW'(data);
                    nxt          = ST_PAY;
                end
            end
            ST_PAY: begin
                if (!status) begin
                    if (rem == '0) begin
                        commit = 1'b1;
                        nxt    = ST_IDLE;
                    end else drop = 1'b1;
                end else if (rem == '0 || full) drop = 1'b1;
                else begin
                    wr_en        = 1'b1;
                    wr_entry.eop = (rem == RW'(1));
                    rem_nxt      = rem - RW'(1);
                end
            end
            ST_DROP: if (!status) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
        if (drop) nxt = status ? ST_DROP : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rem          <= '0;
            fresh        <= 1'b1;
            drop_pulse   <= 1'b0;
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            state      <= nxt;
            rem        <= rem_nxt;
            fresh      <= 1'b0;
            drop_pulse <= drop;
            if (commit && pkt_ok_cnt != '1)  pkt_ok_cnt   <= pkt_ok_cnt + CNT_W'(1);
            if (drop && pkt_drop_cnt != '1)  pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_switch_port_rx.sv
// Directed + randomized bench for switch_port_rx against a packet-level queue model.
module tb_switch_port_rx;
    import switch_pkg::*;

    localparam int DEPTH = 64;
    localparam int MAXL  = 32;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    data;
    logic          status;
    logic          busy;
    logic [7:0]    out_data;
    logic          out_sop, out_eop, out_valid;
    logic          out_ready = 1'b0;
    logic          drop_pulse;
    logic [CW-1:0] pkt_ok_cnt, pkt_drop_cnt;

    switch_port_rx #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .status(status), .busy(busy),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_valid(out_valid), .out_ready(out_ready), .drop_pulse(drop_pulse),
        .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    rx_entry_t  expq[$];
    logic [7:0] pkt[$];
    int exp_ok = 0, exp_drop = 0, drop_seen = 0, rd_count = 0;
    int rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random
    logic       stall_pend = 1'b0;
    logic [9:0] stall_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer / output checker: decides ready at negedge, so a handshake seen
    // here is the one the DUT performs at the following posedge.
    always @(negedge clk) begin
        if (rdy_mode == 0)      out_ready = 1'b0;
        else if (rdy_mode == 1) out_ready = 1'b1;
        else                    out_ready = 1'($urandom_range(0, 1));
        if (drop_pulse) drop_seen++;
        if (!rst_n) stall_pend = 1'b0;
        if (stall_pend) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'({out_sop, out_eop, out_data}), 32'(stall_val));
        end
        stall_pend = 1'b0;
        if (!out_valid) begin
            chk("idle_zero", 32'({out_sop, out_eop, out_data}), 32'd0);
        end else if (out_ready) begin
            if (expq.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
            else begin
                rx_entry_t e;
                e = expq.pop_front();
                chk("out_byte", 32'({out_sop, out_eop, out_data}), 32'(e));
                rd_count++;
            end
        end else begin
            stall_pend = 1'b1;
            stall_val  = {out_sop, out_eop, out_data};
        end
    end

    // Packet-level reference: a packet is kept iff its byte count matches 3+LEN,
    // LEN is legal, and it fits in the space left by committed-but-unread bytes.
    task automatic model_pkt(input logic [7:0] b[$]);
        int  n;
        bit  good;
        n = b.size();
        good = (n >= 3);
        if (good) good = (int'(b[2]) <= MAXL) && (n == 3 + int'(b[2])) && (expq.size() + n <= DEPTH);
        if (good) begin
            for (int i = 0; i < n; i++) begin
                rx_entry_t e;
                e.sop  = (i == 0);
                e.eop  = (i == n - 1);
                e.data = b[i];
                expq.push_back(e);
            end
            exp_ok++;
        end else exp_drop++;
    endtask

    task automatic build(input int len, input int npay);
        pkt.delete();
        pkt.push_back(8'($urandom));
        pkt.push_back(8'($urandom));
        pkt.push_back(8'(len));
        for (int i = 0; i < npay; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic send(input logic [7:0] b[$], input int gap);
        foreach (b[i]) begin
            @(negedge clk);
            data   = b[i];
            status = 1'b1;
        end
        @(negedge clk);
        status = 1'b0;
        data   = 8'h00;
        model_pkt(b);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (expq.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("drain", expq.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        @(negedge clk);
        chk({tag, "_ok"}, 32'(pkt_ok_cnt), exp_ok);
        chk({tag, "_drop"}, 32'(pkt_drop_cnt), exp_drop);
        chk({tag, "_pulses"}, drop_seen, exp_drop);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst_n  = 1'b0;
        status = 1'b0;
        data   = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulse", 32'(drop_pulse), 32'd0);
        chk("rst_ok", 32'(pkt_ok_cnt), 32'd0);
        chk("rst_drop", 32'(pkt_drop_cnt), 32'd0);
        chk("rst_out", 32'({out_sop, out_eop, out_data}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: good packet, commit latency
        rdy_mode = 1;
        pkt = {8'h02, 8'h05, 8'h03, 8'hA1, 8'hA2, 8'hA3};
        foreach (pkt[i]) begin
            @(negedge clk);
            data   = pkt[i];
            status = 1'b1;
        end
        @(negedge clk);
        status = 1'b0;
        model_pkt(pkt);
        chk("t1_valid_before", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_rise", 32'(out_valid), 32'd1);
        wait_drain();
        chk("t1_bytes", rd_count, 32'd6);
        check_counts("t1");

        // T2: too short, then a good packet
        build(4, 2);
        send(pkt, 2);
        chk("t2_no_valid", 32'(out_valid), 32'd0);
        check_counts("t2a");
        build(5, 5);
        send(pkt, 2);
        wait_drain();
        check_counts("t2b");

        // T3: too long; DROP held until status falls, 1-cycle gap, good packet
        build(1, 3);
        foreach (pkt[i]) begin
            @(negedge clk);
            data   = pkt[i];
            status = 1'b1;
            if (i == 5) chk("t3_in_drop", 32'(dut.state), 32'(ST_DROP));
        end
        @(negedge clk);
        status = 1'b0;
        model_pkt(pkt);
        chk("t3_still_drop", 32'(dut.state), 32'(ST_DROP));
        build(2, 2);
        send(pkt, 2);
        wait_drain();
        check_counts("t3");

        // T4: overflow with consumer stalled
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        base = rd_count;
        build(29, 29);
        send(pkt, 1);
        build(29, 29);
        send(pkt, 2);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_ok", 32'(pkt_ok_cnt), exp_ok);
        build(29, 29);
        send(pkt, 2);
        check_counts("t4");
        rdy_mode = 1;
        wait_drain();
        chk("t4_reads", rd_count - base, 32'd64);
        chk("t4_busy_clear", 32'(busy), 32'd0);

        // T5: random backpressure, boundary lengths, random good/bad packets
        rdy_mode = 2;
        pkt = {8'h02, 8'h05, 8'h03, 8'hA1, 8'hA2, 8'hA3};
        send(pkt, 1);
        wait_drain();
        build(0, 0);
        send(pkt, 1);
        wait_drain();
        build(MAXL, MAXL);
        send(pkt, 1);
        wait_drain();
        build(MAXL + 1, 2);
        send(pkt, 1);
        wait_drain();
        for (int p = 0; p < 16; p++) begin
            int kind, len;
            kind = $urandom_range(0, 4);
            len  = $urandom_range(0, MAXL);
            case (kind)
                0: build(len, len);
                1: begin
                    if (len == 0) len = 1;
                    build(len, len - $urandom_range(1, len));
                end
                2: build(len, len + $urandom_range(1, 3));
                3: build($urandom_range(MAXL + 1, 255), $urandom_range(0, 3));
                default: begin
                    build(len, 0);
                    repeat ($urandom_range(1, 2)) void'(pkt.pop_back());
                end
            endcase
            send(pkt, $urandom_range(1, 3));
            wait_drain();
        end
        check_counts("t5");

        // T6: reset mid-packet, released while status is still high
        rdy_mode = 1;
        build(5, 5);
        @(negedge clk);
        data = pkt[0]; status = 1'b1;
        @(negedge clk);
        data = pkt[1];
        @(negedge clk);
        data  = pkt[2];
        rst_n = 1'b0;
        expq.delete();
        exp_ok = 0; exp_drop = 0; drop_seen = 0;
        repeat (2) @(negedge clk);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ok", 32'(pkt_ok_cnt), 32'd0);
        chk("t6_rst_drop", 32'(pkt_drop_cnt), 32'd0);
        chk("t6_rst_pulse", 32'(drop_pulse), 32'd0);
        rst_n = 1'b1;
        for (int i = 3; i < 8; i++) begin
            data = pkt[i];
            @(negedge clk);
        end
        status = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_ignored_valid", 32'(out_valid), 32'd0);
        chk("t6_ignored_ok", 32'(pkt_ok_cnt), 32'd0);
        build(4, 4);
        send(pkt, 2);
        wait_drain();
        chk("t6_next_ok", 32'(pkt_ok_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
